// File: rtl/pe_mac_gen.sv
// Systolic-array PE: registered multiply, windowed accumulate, one-cycle neighbour forwarding.
// Define PE_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned CNT_W    = 8,
  parameter bit          SIGNED   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                fire_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [WEIGHT_W-1:0] weight_in,
  output logic                fire_out,
  output logic [DATA_W-1:0]   data_out,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic [ACC_W-1:0]    result,
  output logic                result_valid,
  output logic [CNT_W-1:0]    result_cnt,
  output logic                result_ovf
);

  localparam int unsigned ProdW = DATA_W + WEIGHT_W;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e             state_q;
  logic [ProdW-1:0]   prod_q, prod_d;
  logic               fire_q;
  logic [ACC_W-1:0]   acc_q, acc_add, prod_ext;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic               ovf_q, sum_ovf;
  logic [ProdW-1:0]   data_x, weight_x;
  logic [ACC_W:0]     sum;

  // Extending both operands to the product width makes one unsigned multiply
  // give the correct low bits for either signedness.
  always_comb begin
    data_x   = {{WEIGHT_W{SIGNED & data_in[DATA_W-1]}}, data_in};
    weight_x = {{DATA_W{SIGNED & weight_in[WEIGHT_W-1]}}, weight_in};
    prod_d   = data_x * weight_x;
  end

  always_comb begin
    prod_ext = ACC_W'(prod_q);
    for (int i = ProdW; i < ACC_W; i++) begin
      prod_ext[i] = SIGNED & prod_q[ProdW-1];
    end
  end

  always_comb begin
    sum     = {SIGNED & acc_q[ACC_W-1], acc_q} + {SIGNED & prod_ext[ACC_W-1], prod_ext};
    sum_ovf = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PE_SAT_EN
    // Unsigned sums can only overflow upward, so the top clamp suffices there.
    if (!sum_ovf) begin
      acc_add = sum[ACC_W-1:0];
    end else if (!SIGNED) begin
      acc_add = {ACC_W{1'b1}};
    end else if (sum[ACC_W]) begin
      acc_add = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_add = {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    acc_add = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prod_q       <= '0;
      fire_q       <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      fire_out     <= 1'b0;
      data_out     <= '0;
      weight_out   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_cnt   <= '0;
      result_ovf   <= 1'b0;
    end else if (!hold) begin
      prod_q       <= prod_d;
      fire_q       <= fire_in;
      fire_out     <= fire_in;
      data_out     <= data_in;
      weight_out   <= weight_in;
      result_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fire_q) begin
            acc_q   <= prod_ext;
            cnt_q   <= CNT_W'(1);
            ovf_q   <= 1'b0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (fire_q) begin
            acc_q <= acc_add;
            cnt_q <= cnt_inc;
            ovf_q <= ovf_q | sum_ovf;
          end else begin
            result       <= acc_q;
            result_cnt   <= cnt_q;
            result_ovf   <= ovf_q;
            result_valid <= 1'b1;
            acc_q        <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_gen.sv
// Scoreboard bench for pe_mac_gen: default signed PE, a 16-bit accumulator variant
// (PE_SAT_EN-dependent expectation) and an unsigned variant.
module tb_pe_mac_gen;

  logic       clk = 1'b0;
  logic       rst, hold;
  logic [2:0] fire;
  logic [7:0] din, win;

  always #5 clk = ~clk;

  logic        fo_a, fo_b, fo_c;
  logic [7:0]  do_a, do_b, do_c, wo_a, wo_b, wo_c;
  logic [31:0] res_a, res_c;
  logic [15:0] res_b;
  logic        vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c;
  logic [7:0]  cnt_a, cnt_b, cnt_c;

  pe_mac_gen u_dut_a (
    .clk(clk), .rst(rst), .hold(hold), .fire_in(fire[0]), .data_in(din), .weight_in(win),
    .fire_out(fo_a), .data_out(do_a), .weight_out(wo_a), .result(res_a),
    .result_valid(vld_a), .result_cnt(cnt_a), .result_ovf(ovf_a)
  );

  pe_mac_gen #(.ACC_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .hold(hold), .fire_in(fire[1]), .data_in(din), .weight_in(win),
    .fire_out(fo_b), .data_out(do_b), .weight_out(wo_b), .result(res_b),
    .result_valid(vld_b), .result_cnt(cnt_b), .result_ovf(ovf_b)
  );

  pe_mac_gen #(.SIGNED(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .hold(hold), .fire_in(fire[2]), .data_in(din), .weight_in(win),
    .fire_out(fo_c), .data_out(do_c), .weight_out(wo_c), .result(res_c),
    .result_valid(vld_c), .result_cnt(cnt_c), .result_ovf(ovf_c)
  );

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] res;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int          rise_a[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [2:0]  vld, ovf;
  logic [31:0] res [3];
  logic [7:0]  cnt [3];

  assign vld    = {vld_c, vld_b, vld_a};
  assign ovf    = {ovf_c, ovf_b, ovf_a};
  assign res[0] = res_a;
  assign res[1] = {16'h0, res_b};
  assign res[2] = res_c;
  assign cnt[0] = cnt_a;
  assign cnt[1] = cnt_b;
  assign cnt[2] = cnt_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [7:0] d, input logic [7:0] w);
    fire = f;
    din  = d;
    win  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input int idx, input int maxc);
    int n = 0;
    while (!vld[idx] && n < maxc) begin
      fire = 3'b000;
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("valid_seen_%0d", idx), {31'b0, vld[idx]}, 32'd1);
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: one scoreboard pop per result_valid pulse, however long hold stretches it.
  initial begin
    logic [2:0] seen = 3'b000;
    exp_t       e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (vld[i] && !seen[i]) begin
          seen[i] = 1'b1;
          if (i == 0) rise_a.push_back(cyc);
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_valid_%0d", i), {31'b0, vld[i]}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_inst", i, {30'b0, e.inst});
            chk("sb_result", res[i], e.res);
            chk("sb_cnt", {24'b0, cnt[i]}, {24'b0, e.cnt});
            chk("sb_ovf", {31'b0, ovf[i]}, {31'b0, e.ovf});
          end
        end else if (!vld[i]) begin
          seen[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    drive(3'b000, 8'h00, 8'h00);
    drive(3'b000, 8'h00, 8'h00);
    chk("rst_result", res_a, 32'h0);
    chk("rst_valid", {31'b0, vld_a}, 32'd0);
    chk("rst_fire_out", {31'b0, fo_a}, 32'd0);
    chk("rst_cnt", {24'b0, cnt_a}, 32'd0);
    rst = 1'b0;

    // Signed mix: 3*4 + (-2)*4 + 5*(-1) = -1
    sb.push_back('{2'd0, 32'hFFFF_FFFF, 8'd3, 1'b0});
    drive(3'b001, 8'd3, 8'd4);
    chk("fwd_fire", {31'b0, fo_a}, 32'd1);
    chk("fwd_data", {24'b0, do_a}, 32'd3);
    chk("fwd_weight", {24'b0, wo_a}, 32'd4);
    drive(3'b001, 8'hFE, 8'd4);
    chk("fwd_data_neg", {24'b0, do_a}, 32'h0000_00FE);
    drive(3'b001, 8'd5, 8'hFF);
    chk("fwd_weight_neg", {24'b0, wo_a}, 32'h0000_00FF);
    drive(3'b000, 8'h00, 8'h00);
    chk("t1_fire_out_low", {31'b0, fo_a}, 32'd0);
    chk("t1_valid_L", {31'b0, vld_a}, 32'd0);
    drive(3'b000, 8'h00, 8'h00);
    chk("t1_valid_L1", {31'b0, vld_a}, 32'd1);
    drive(3'b000, 8'h00, 8'h00);
    chk("t1_valid_L2", {31'b0, vld_a}, 32'd0);

    // Back-to-back windows separated by a single low cycle.
    sb.push_back('{2'd0, 32'd6, 8'd1, 1'b0});
    sb.push_back('{2'd0, 32'd21, 8'd2, 1'b0});
    drive(3'b001, 8'd2, 8'd3);
    drive(3'b000, 8'd0, 8'd0);
    drive(3'b001, 8'd4, 8'd5);
    drive(3'b001, 8'd1, 8'd1);
    drive(3'b000, 8'd0, 8'd0);
    wait_vld(0, 5);
    drive(3'b000, 8'd0, 8'd0);
    if (rise_a.size() >= 2) begin
      chk("b2b_gap", rise_a[rise_a.size()-1] - rise_a[rise_a.size()-2], 32'd3);
    end else begin
      chk("b2b_pulses", rise_a.size(), 32'd3);
    end

    // Hold mid-window and across the valid pulse.
    sb.push_back('{2'd0, 32'hFFFF_FFFF, 8'd3, 1'b0});
    drive(3'b001, 8'd3, 8'd4);
    drive(3'b001, 8'hFE, 8'd4);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 8'd9, 8'd9);
      chk("hold_data_out", {24'b0, do_a}, 32'h0000_00FE);
      chk("hold_fire_out", {31'b0, fo_a}, 32'd1);
    end
    hold = 1'b0;
    drive(3'b001, 8'd5, 8'hFF);
    drive(3'b000, 8'd0, 8'd0);
    drive(3'b000, 8'd0, 8'd0);
    chk("hold_valid_rise", {31'b0, vld_a}, 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 8'd0, 8'd0);
      chk("hold_valid_kept", {31'b0, vld_a}, 32'd1);
    end
    hold = 1'b0;
    drive(3'b000, 8'd0, 8'd0);
    chk("hold_valid_end", {31'b0, vld_a}, 32'd0);

    // Reset mid-window discards it; fire right after release opens a new one.
    drive(3'b001, 8'd1, 8'd1);
    drive(3'b001, 8'd1, 8'd1);
    rst = 1'b1;
    drive(3'b001, 8'd1, 8'd1);
    chk("rst2_result", res_a, 32'h0);
    chk("rst2_data_out", {24'b0, do_a}, 32'd0);
    chk("rst2_weight_out", {24'b0, wo_a}, 32'd0);
    chk("rst2_fire_out", {31'b0, fo_a}, 32'd0);
    chk("rst2_valid", {31'b0, vld_a}, 32'd0);
    drive(3'b001, 8'd1, 8'd1);
    rst = 1'b0;
    sb.push_back('{2'd0, 32'd49, 8'd1, 1'b0});
    drive(3'b001, 8'd7, 8'd7);
    drive(3'b000, 8'd0, 8'd0);
    wait_vld(0, 5);
    drive(3'b000, 8'd0, 8'd0);

    // 16-bit accumulator: 3 * 16129 = 48387 overflows signed 16-bit.
`ifdef PE_SAT_EN
    sb.push_back('{2'd1, 32'h0000_7FFF, 8'd3, 1'b1});
`else
    sb.push_back('{2'd1, 32'h0000_BD03, 8'd3, 1'b1});
`endif
    for (int i = 0; i < 3; i++) drive(3'b010, 8'd127, 8'd127);
    drive(3'b000, 8'd0, 8'd0);
    wait_vld(1, 5);
    drive(3'b000, 8'd0, 8'd0);

    // Unsigned: 2 * 200 * 200 = 80000
    sb.push_back('{2'd2, 32'd80000, 8'd2, 1'b0});
    drive(3'b100, 8'd200, 8'd200);
    drive(3'b100, 8'd200, 8'd200);
    drive(3'b000, 8'd0, 8'd0);
    wait_vld(2, 5);
    drive(3'b000, 8'd0, 8'd0);
    drive(3'b000, 8'd0, 8'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_gen.md
# pe_mac_gen

Parametrised systolic-array processing element that replaces the fixed 8-bit PE in the array tiles. Each PE multiplies streaming data by streaming weight in a registered multiplier stage and accumulates over a `fire_in` window. It forwards data, weight and fire to its neighbours with one cycle of latency. At window end it publishes the sum with a one-cycle valid pulse, a MAC count and an overflow flag. It also supports signed or unsigned arithmetic and a global pipeline hold.

## Interface
- `DATA_W`, 8: data operand width.
- `WEIGHT_W`, 8: weight operand width.
- `ACC_W`, 32: accumulator/result width. Must satisfy `ACC_W >= DATA_W+WEIGHT_W`.
- `CNT_W`, 8: MAC-count width.
- `SIGNED`, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `hold`  in  1  freezes every register in the block (including forwarding registers) while high.
- `fire_in`  in  1  accumulation window marker.
- `data_in`  in  DATA_W  data operand.
- `weight_in`  in  WEIGHT_W  weight operand.
- `fire_out`  out  1  `fire_in` delayed one cycle.
- `data_out`  out  DATA_W  `data_in` delayed one cycle.
- `weight_out`  out  WEIGHT_W  `weight_in` delayed one cycle.
- `result`  out  ACC_W  accumulated sum of the last completed window; held until the next window completes.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `result_cnt`  out  CNT_W  number of products in that window; saturates at all-ones.
- `result_ovf`  out  1  set if any accumulation in that window overflowed `ACC_W`.

## Operation
- **Stage 1 (every non-hold cycle):**
  - `prod_q <= data_in*weight_in`, computed at width `DATA_W+WEIGHT_W` and signed per `SIGNED`.
  - `fire_q <= fire_in`.
  - The forwarding registers load from their inputs.
- **FSM states:** IDLE and ACCUM.
- **IDLE, `fire_q`=1:**
  - `acc <= ext(prod_q)`, where ext is sign- or zero-extension per `SIGNED`.
  - `cnt <= 1`, `ovf <= 0`.
  - Go to ACCUM.
- **IDLE, `fire_q`=0:** nothing changes.
- **ACCUM, `fire_q`=1:**
  - `acc <= acc + ext(prod_q)`.
  - `cnt` increments, saturating at 2^CNT_W-1.
  - `ovf` sets if the `ACC_W+1`-bit true sum is not representable in `ACC_W` bits (signed or unsigned range per `SIGNED`).
- **ACCUM, `fire_q`=0 (drain):**
  - `result <= acc`, `result_cnt <= cnt`, `result_ovf <= ovf`.
  - `result_valid`=1 for exactly this one cycle.
  - `acc` clears to 0; go to IDLE.
- **Back-to-back windows:** a single low `fire_in` cycle between two windows is sufficient. The drain cycle and the next window's first product never coincide.
- **`hold`=1:**
  - All state, outputs and the FSM keep their values.
  - `result_valid` holds its value too: a pulse spanning a hold lasts until the first non-hold cycle that follows it.
- **Reset:** synchronous, has priority over `hold`.
  - All outputs, `acc`, `cnt`, `ovf`, `prod_q` and `fire_q` go to 0; FSM goes to IDLE.
  - A window in progress is discarded with no `result_valid`.

## Timing
- Forwarding latency is 1 cycle.
- A product sampled at edge t is included in `acc` after edge t+1.
- Let L be the first edge sampling `fire_in`=0 after a window. `result_valid` is high in the cycle after edge L+1, i.e. two cycles after the first low sample.
- A window of one high cycle is legal and yields `result_cnt`=1.
- Fire sampled high at the first edge after reset release opens a window normally.

## Configuration
- Macro: `PE_SAT_EN`.
- **Defined:** on overflow the accumulator clamps and `ovf` is set.
  - Signed clamp limits: 2^(ACC_W-1)-1 / -2^(ACC_W-1).
  - Unsigned clamp limits: 2^ACC_W-1 / 0.
  - Clamped values keep accumulating from the clamp value.
- **Undefined:** the accumulator wraps modulo 2^ACC_W; `ovf` is still reported.

## Test plan
1. **Signed mix (defaults):** data 3, -2, 5 with weight 4, 4, -1 over 3 fire cycles.
   - `result`=0xFFFFFFFF (-1), `result_cnt`=3, `result_ovf`=0.
   - `result_valid` pulses once, two cycles after fire drops.
   - `fire_out`/`data_out`/`weight_out` mirror the inputs one cycle late.
2. **Overflow, `ACC_W`=16, SIGNED:** data 127, weight 127 for 3 cycles.
   - With `PE_SAT_EN`: `result`=32767.
   - Without: `result`=-17149.
   - `result_ovf`=1 in both builds.
3. **Unsigned (`SIGNED`=0):** data 200, weight 200 for 2 cycles → `result`=80000, `result_cnt`=2.
4. **Back-to-back windows:** windows {2×3} and {4×5, 1×1} separated by one low cycle.
   - Two `result_valid` pulses, 3 cycles apart.
   - Results 6 then 21; `result_cnt` 1 then 2.
5. **Hold:** assert `hold` for 4 cycles mid-window and again during the `result_valid` pulse.
   - Same sum as an unheld run.
   - Forwarding outputs frozen during hold.
   - The pulse extends across the hold.
6. **Reset mid-window:** assert `rst` after 2 of 4 fire cycles.
   - No `result_valid`; all outputs 0.
   - A new 1-cycle window 7×7 afterwards gives `result`=49, `result_cnt`=1.
